// File: rtl/fir_pipe.sv
// rtl/fir_pipe.sv - pipelined direct-form FIR with double-buffered coefficient bank
module fir_pipe #(
    parameter int XW    = 16,
    parameter int COEFW = 18,
    parameter int NTAPS = 8,
    parameter int ACCW  = 48,
    parameter int SHIFT = 15,
    parameter int OUTW  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [XW-1:0]    in_x,
    output logic                    out_valid,
    output logic signed [OUTW-1:0]  out_y,
    output logic                    out_sat,
    input  logic                    coef_valid,
    input  logic signed [COEFW-1:0] coef_data,
    output logic                    coef_ready,
    input  logic                    coef_commit,
    output logic                    bank_sel
);
    localparam int LVL = $clog2(NTAPS);
    localparam int P   = 1 << LVL;
    localparam int PW  = XW + COEFW;
    localparam int LAT = 3 + LVL;
    localparam int RS  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACCW:0] RND = (SHIFT > 0) ? ({{ACCW{1'b0}}, 1'b1} << RS) : '0;

    typedef enum logic {LOAD, FULL} ld_state_t;

    ld_state_t               ld_state;
    logic [LVL-1:0]          idx;
    logic signed [COEFW-1:0] shadow  [NTAPS];
    logic signed [COEFW-1:0] active  [NTAPS];
    logic signed [XW-1:0]    hist    [NTAPS];
    logic signed [COEFW-1:0] coef_s1 [NTAPS];
    logic signed [PW-1:0]    prod    [NTAPS];
    logic signed [ACCW-1:0]  kid     [2:2*P-1];
    logic signed [ACCW-1:0]  node    [1:P-1];
    logic [LAT-1:1]          vpipe;
    logic signed [ACCW:0]    rounded;
    logic signed [ACCW:0]    shifted;
    logic [ACCW-OUTW+1:0]    hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state   <= LOAD;
            idx        <= '0;
            coef_ready <= 1'b1;
            bank_sel   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            case (ld_state)
                LOAD: begin
                    if (coef_valid) begin
                        shadow[idx] <= coef_data;
                        if (idx == LVL'(NTAPS - 1)) begin
                            ld_state   <= FULL;
                            idx        <= '0;
                            coef_ready <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (coef_commit) begin
                        ld_state   <= LOAD;
                        coef_ready <= 1'b1;
                        bank_sel   <= ~bank_sel;
                        for (int k = 0; k < NTAPS; k++) active[k] <= shadow[k];
                    end
                end
            endcase
        end
    end

    // Each sample carries the coefficient set that was active when it entered,
    // so a swap can never split one output across two banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                hist[k]    <= '0;
                coef_s1[k] <= '0;
                prod[k]    <= '0;
            end
        end else begin
            vpipe <= {vpipe[LAT-2:1], in_valid};
            if (in_valid) begin
                hist[0] <= in_x;
                for (int k = 1; k < NTAPS; k++) hist[k] <= hist[k-1];
                for (int k = 0; k < NTAPS; k++) coef_s1[k] <= active[k];
            end
            for (int k = 0; k < NTAPS; k++) prod[k] <= hist[k] * coef_s1[k];
        end
    end

    genvar g;
    generate
        for (g = 2; g < 2 * P; g++) begin : g_kid
            if (g >= P + NTAPS) begin : g_pad
                assign kid[g] = '0;
            end else if (g >= P) begin : g_tap
                assign kid[g] = {{(ACCW - PW){prod[g-P][PW-1]}}, prod[g-P]};
            end else begin : g_inner
                assign kid[g] = node[g];
            end
        end
    endgenerate

    // Heap-ordered adder tree: node[1] is the root, one register per level.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < P; i++) node[i] <= '0;
        end else begin
            for (int i = 1; i < P; i++) node[i] <= kid[2*i] + kid[2*i+1];
        end
    end

    always_comb begin
        rounded = {node[1][ACCW-1], node[1]} + RND;
        shifted = rounded >>> SHIFT;
        hi      = shifted[ACCW:OUTW-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= vpipe[LAT-1];
            if (vpipe[LAT-1]) begin
                if (hi == '0 || hi == '1) begin
                    out_y   <= shifted[OUTW-1:0];
                    out_sat <= 1'b0;
                end else if (shifted[ACCW]) begin
                    out_y   <= {1'b1, {(OUTW-1){1'b0}}};
                    out_sat <= 1'b1;
                end else begin
                    out_y   <= {1'b0, {(OUTW-1){1'b1}}};
                    out_sat <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_pipe.sv
// tb/tb_fir_pipe.sv - randomized and directed checks of fir_pipe against a convolution model
module tb_fir_pipe;
    localparam int NT  = 8;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic signed [15:0] in_x = '0;
    logic coef_valid = 1'b0;
    logic signed [17:0] coef_data = '0;
    logic coef_commit = 1'b0;

    logic ov [3];
    logic signed [15:0] oy [3];
    logic osat [3];
    logic rdy [3];
    logic bsel [3];

    always #5 clk = ~clk;

    fir_pipe #(.SHIFT(0)) u_s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x),
        .out_valid(ov[0]), .out_y(oy[0]), .out_sat(osat[0]),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(rdy[0]),
        .coef_commit(coef_commit), .bank_sel(bsel[0])
    );
    fir_pipe #(.SHIFT(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x),
        .out_valid(ov[1]), .out_y(oy[1]), .out_sat(osat[1]),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(rdy[1]),
        .coef_commit(coef_commit), .bank_sel(bsel[1])
    );
    fir_pipe #(.SHIFT(15)) u_s15 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x),
        .out_valid(ov[2]), .out_y(oy[2]), .out_sat(osat[2]),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(rdy[2]),
        .coef_commit(coef_commit), .bank_sel(bsel[2])
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit checking = 1'b0;
    int shifts [3] = '{0, 1, 15};

    typedef struct {
        int     due;
        longint y;
    } exp_t;

    longint m_hist [NT];
    longint m_act [NT];
    longint m_shd [NT];
    int     m_cnt = 0;
    bit     m_full = 1'b0;
    bit     m_bank = 1'b0;
    exp_t   expq [$];
    bit     e_valid = 1'b0;
    logic signed [15:0] e_y [3] = '{16'sd0, 16'sd0, 16'sd0};
    bit     e_sat [3] = '{1'b0, 1'b0, 1'b0};

    longint log0 [$];
    longint log1 [$];
    longint logc [$];
    bit     logs0 [$];
    longint stamps [$];
    bit     nswaps = 1'b0;

    task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint rnd_sat(longint y, int s, output bit sat);
        longint r;
        if (s > 0) r = (y + (longint'(1) <<< (s - 1))) >>> s;
        else r = y;
        sat = (r > 32767) || (r < -32768);
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference: plain convolution over a sample history, results queued with their due cycle.
    always @(posedge clk) begin
        longint sum;
        longint r;
        bit s;
        if (reset) begin
            for (int k = 0; k < NT; k++) begin
                m_hist[k] = 0;
                m_act[k] = 0;
                m_shd[k] = 0;
            end
            m_cnt = 0;
            m_full = 1'b0;
            m_bank = 1'b0;
            expq.delete();
            e_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                e_y[i] = '0;
                e_sat[i] = 1'b0;
            end
        end else begin
            if (in_valid) begin
                for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = in_x;
                sum = 0;
                for (int k = 0; k < NT; k++) sum += m_act[k] * m_hist[k];
                expq.push_back('{due: cyc + LAT, y: sum});
            end
            if (m_full && coef_commit) begin
                m_act = m_shd;
                m_full = 1'b0;
                m_bank = ~m_bank;
            end else if (!m_full && coef_valid) begin
                m_shd[m_cnt] = coef_data;
                m_cnt++;
                if (m_cnt == NT) begin
                    m_full = 1'b1;
                    m_cnt = 0;
                end
            end
            if (expq.size() > 0 && expq[0].due == cyc + 1) begin
                e_valid = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    r = rnd_sat(expq[0].y, shifts[i], s);
                    e_y[i] = 16'(r);
                    e_sat[i] = s;
                end
                void'(expq.pop_front());
            end else begin
                e_valid = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("out_valid s%0d", shifts[i]), 64'(ov[i]), 64'(e_valid));
                check($sformatf("out_y s%0d", shifts[i]), 64'(oy[i]), 64'(e_y[i]));
                check($sformatf("out_sat s%0d", shifts[i]), 64'(osat[i]), 64'(e_sat[i]));
                check($sformatf("coef_ready s%0d", shifts[i]), 64'(rdy[i]), 64'(!m_full));
                check($sformatf("bank_sel s%0d", shifts[i]), 64'(bsel[i]), 64'(m_bank));
            end
        end
        if (ov[0] === 1'b1) begin
            log0.push_back(oy[0]);
            logs0.push_back(osat[0]);
            logc.push_back(cyc);
        end
        if (ov[1] === 1'b1) log1.push_back(oy[1]);
    end

    function automatic longint at0(int i);
        return (i < log0.size()) ? log0[i] : -999999;
    endfunction

    function automatic longint at1(int i);
        return (i < log1.size()) ? log1[i] : -999999;
    endfunction

    function automatic longint lat(int i);
        return (i < logc.size() && i < stamps.size()) ? logc[i] - stamps[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        coef_valid = 1'b0;
        coef_commit = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(int x);
        in_valid = 1'b1;
        in_x = 16'(x);
        stamps.push_back(cyc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic signed [17:0] c [NT], input bit commit_on_last);
        for (int k = 0; k < NT; k++) begin
            coef_valid = 1'b1;
            coef_data = c[k];
            coef_commit = commit_on_last && (k == NT - 1);
            tick();
        end
        coef_valid = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic install(input logic signed [17:0] c [NT]);
        load(c, 1'b0);
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        nswaps = ~nswaps;
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        logc.delete();
        logs0.delete();
        stamps.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [17:0] cs [NT];
        int t_commit;
        int tmp;
        int sel;

        reset = 1'b1;
        repeat (3) tick();
        checking = 1'b1;
        check("reset out_valid", 64'(ov[0]), 64'd0);
        check("reset out_y", 64'(oy[0]), 64'd0);
        check("reset coef_ready", 64'(rdy[0]), 64'd1);
        check("reset bank_sel", 64'(bsel[0]), 64'd0);
        reset = 1'b0;

        // Impulse with continuous valid, coefficients 1..8
        for (int k = 0; k < NT; k++) cs[k] = 18'(k + 1);
        install(cs);
        clear_logs();
        send(1);
        repeat (11) send(0);
        idle(8);
        check("impulse count", log0.size(), 12);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("impulse y[%0d]", i), at0(i), (i < 8) ? i + 1 : 0);
        end
        check("impulse latency", lat(0), LAT);

        // Same impulse with a sample every third cycle
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            send(i == 0 ? 1 : 0);
            idle(2);
        end
        idle(8);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("gapped y[%0d]", i), at0(i), (i < 8) ? i + 1 : 0);
            check($sformatf("gapped latency[%0d]", i), lat(i), LAT);
        end

        // Rounding with c0=1
        for (int k = 0; k < NT; k++) cs[k] = (k == 0) ? 18'sd1 : 18'sd0;
        install(cs);
        clear_logs();
        send(3);
        send(-3);
        send(-4);
        idle(8);
        check("round s1 +3", at1(0), 2);
        check("round s1 -3", at1(1), -1);
        check("round s1 -4", at1(2), -2);
        check("round s0 -4", at0(2), -4);

        // Saturation with all coefficients at full scale
        for (int k = 0; k < NT; k++) cs[k] = 18'sd131071;
        install(cs);
        clear_logs();
        repeat (16) send(32767);
        repeat (16) send(-32768);
        idle(8);
        check("sat pos y", at0(12), 32767);
        check("sat pos flag", (12 < logs0.size()) ? logs0[12] : 0, 1);
        check("sat neg y", at0(28), -32768);
        check("sat neg flag", (28 < logs0.size()) ? logs0[28] : 0, 1);

        // Bank swap: active c0=1, shadow c0=2, commit on the final word is ignored
        for (int k = 0; k < NT; k++) cs[k] = (k == 0) ? 18'sd1 : 18'sd0;
        install(cs);
        cs[0] = 18'sd2;
        load(cs, 1'b1);
        check("ready low when full", 64'(rdy[0]), 64'd0);
        check("bank after ignored commit", 64'(bsel[0]), 64'(nswaps));
        clear_logs();
        t_commit = -1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) check("bank at commit cycle", 64'(bsel[0]), 64'(nswaps));
            if (i == 9) begin
                check("bank after commit", 64'(bsel[0]), 64'(!nswaps));
                check("ready after commit", 64'(rdy[0]), 64'd1);
            end
            in_valid = 1'b1;
            in_x = 16'sd5;
            coef_commit = (i == 8);
            if (i == 8) t_commit = cyc;
            stamps.push_back(cyc);
            tick();
        end
        nswaps = ~nswaps;
        idle(8);
        check("swap count", log0.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("swap y[%0d]", i), at0(i),
                  (i < stamps.size() && stamps[i] <= t_commit) ? 5 : 10);
        end

        // Randomized traffic, including occasional resets
        for (int n = 0; n < 2500; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            if (sel == 0) in_x = 16'sh8000;
            else if (sel == 1) in_x = 16'sh7fff;
            else in_x = 16'($urandom);
            coef_valid = $urandom_range(0, 1);
            tmp = int'($urandom_range(0, 8000)) - 4000;
            coef_data = 18'(tmp);
            coef_commit = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        nswaps = 1'b0;

        // Reset three cycles after an impulse
        for (int k = 0; k < NT; k++) cs[k] = 18'(k + 1);
        install(cs);
        clear_logs();
        send(1);
        send(0);
        send(0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_x = 16'sd7;
        tick();
        reset = 1'b0;
        idle(10);
        check("no output after reset", log0.size(), 0);
        check("post-reset out_y", 64'(oy[0]), 64'd0);
        check("post-reset out_valid", 64'(ov[0]), 64'd0);
        check("post-reset bank_sel", 64'(bsel[0]), 64'd0);
        clear_logs();
        send(1);
        repeat (8) send(0);
        idle(8);
        check("fresh impulse count", log0.size(), 9);
        check("fresh impulse y0", at0(0), 0);
        check("fresh impulse y4", at0(4), 0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
